idiv: RTL and testbench

- Parametrised iterative divider: 2W-by-W, one quotient bit per clock.
- Generalises the unsigned divider with a per-operation signed/unsigned mode, a distinct divide-by-zero flag, a one-cycle done strobe and a post-divide signed-range check.
- Sits beside the CPU ALU as a multi-cycle coprocessor. Started with go; polled via busy or done.

---
 rtl/idiv.sv | 164 ++++++++++++++++
 tb/tb_idiv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/idiv.sv
// Iterative 2W-by-W divider with an unsigned or signed mode per operation.
// It produces one quotient bit per clock using restoring shift-subtract, then applies a sign fixup.
module idiv #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 go,
    input  logic                 sgn,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem,
    output logic                 overflow,
    output logic                 divzero,
    output logic [1:0]           o_dbg_state
);
    // Handshake: go is taken on a rising edge only while busy=0 (IDLE or DONE).
    // done pulses for one cycle after the result lands, and the results hold until the next accepted go.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_div;
    logic [CW-1:0]        r_cnt;
    logic                 r_sgn;
    logic                 r_qsign;
    logic                 r_rsign;
    logic                 r_ovf;
    logic                 r_dz;

    logic                 w_dvd_neg;
    logic                 w_dvs_neg;
    logic [2*WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]     w_dvs_mag;
    logic                 w_dz;
    logic                 w_pre_ovf;
    logic                 w_pre_fail;
    logic                 w_accept;
    logic [WIDTH:0]       w_trial;
    logic                 w_sub;
    logic                 w_range_ovf;

    assign w_dvd_neg  = sgn & dividend[2*WIDTH-1];
    assign w_dvs_neg  = sgn & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
    assign w_dz       = (divisor == '0);
    assign w_pre_ovf  = (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag);
    assign w_pre_fail = w_dz | w_pre_ovf;
    assign w_accept   = go & ((r_state == S_IDLE) | (r_state == S_DONE));

    // If rem[W-1] is set, the shifted partial remainder exceeds 2^W, so the subtract always fits.
    assign w_trial = {1'b0, r_rem[WIDTH-2:0], r_quot[WIDTH-1]} - {1'b0, r_div};
    assign w_sub   = ~w_trial[WIDTH] | r_rem[WIDTH-1];

    // Signed limits on the magnitude: a positive result must be <= 2^(W-1)-1, a negative one <= 2^(W-1).
    assign w_range_ovf = r_sgn & (r_qsign ? (r_quot[WIDTH-1] & (|r_quot[WIDTH-2:0]))
                                          : r_quot[WIDTH-1]);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_pre_fail ? S_DONE : S_ITER;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ITER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIXUP;
                end
            end
            S_FIXUP: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == S_ITER) | (r_state == S_FIXUP);
        done        = (r_state == S_DONE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_sgn   <= 1'b0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_sgn <= sgn;
                        if (w_pre_fail) begin
                            r_quot <= '1;
                            r_rem  <= '1;
                            r_ovf  <= 1'b1;
                            r_dz   <= w_dz;
                        end else begin
                            r_rem   <= w_dvd_mag[2*WIDTH-1:WIDTH];
                            r_quot  <= w_dvd_mag[WIDTH-1:0];
                            r_div   <= w_dvs_mag;
                            r_cnt   <= CW'(WIDTH - 1);
                            r_qsign <= w_dvd_neg ^ w_dvs_neg;
                            r_rsign <= w_dvd_neg;
                            r_ovf   <= 1'b0;
                            r_dz    <= 1'b0;
                        end
                    end
                end
                S_ITER: begin
                    r_rem  <= w_sub ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
                    r_quot <= {r_quot[WIDTH-2:0], w_sub};
                    r_cnt  <= r_cnt - CW'(1);
                end
                S_FIXUP: begin
                    if (w_range_ovf) begin
                        r_quot <= '1;
                        r_rem  <= '1;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_quot <= r_qsign ? -r_quot : r_quot;
                        r_rem  <= r_rsign ? -r_rem : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quot     = r_quot;
    assign rem      = r_rem;
    assign overflow = r_ovf;
    assign divzero  = r_dz;

endmodule

// File: tb/tb_idiv.sv
// Directed bench for idiv at WIDTH=8, with expected values computed by hand from the arithmetic.
// It covers normal, signed, range-edge, divide-by-zero, back-to-back, ignored-go and mid-operation reset cases.
module tb_idiv;
    localparam int W = 8;

    logic           clk;
    logic           arstn;
    logic           go;
    logic           sgn;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           overflow;
    logic           divzero;
    logic [1:0]     dbg_state;

    int checks   = 0;
    int failures = 0;

    idiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .arstn       (arstn),
        .go          (go),
        .sgn         (sgn),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .overflow    (overflow),
        .divzero     (divzero),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Latency is the number of edges from the accepting edge up to the cycle where done is seen.
    task automatic run_op(input logic s, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                          input bit hold, output int lat, output int bcnt);
        sgn = s; dividend = dvd; divisor = dvs; go = 1'b1;
        lat = 0; bcnt = 0;
        do begin
            tick();
            lat++;
            if (!hold) go = 1'b0;
            if (busy) bcnt++;
        end while (!done && lat < 40);
    endtask

    int lat;
    int bcnt;
    int n;
    bit seen_done;

    initial begin
        arstn = 1'b0; go = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dz", divzero, 0);
        arstn = 1'b1;
        tick();

        // 1000 / 7 = 142 r 6
        run_op(1'b0, 16'd1000, 8'd7, 1'b0, lat, bcnt);
        chk("u_lat", lat, 10);
        chk("u_busy_cycles", bcnt, 9);
        chk("u_quot", quot, 8'h8E);
        chk("u_rem", rem, 8'h06);
        chk("u_ovf", overflow, 0);
        chk("u_dz", divzero, 0);
        tick();
        chk("u_done_one_cycle", done, 0);
        chk("u_quot_hold", quot, 8'h8E);

        // -100 / 7 = -14 r -2
        run_op(1'b1, 16'hFF9C, 8'd7, 1'b0, lat, bcnt);
        chk("s1_lat", lat, 10);
        chk("s1_quot", quot, 8'hF2);
        chk("s1_rem", rem, 8'hFE);
        chk("s1_ovf", overflow, 0);
        tick();

        // 100 / -7 = -14 r 2
        run_op(1'b1, 16'd100, 8'hF9, 1'b0, lat, bcnt);
        chk("s2_quot", quot, 8'hF2);
        chk("s2_rem", rem, 8'h02);
        chk("s2_ovf", overflow, 0);
        tick();

        // 128 / 1 signed: passes pre-check, fails the range check at fixup
        run_op(1'b1, 16'd128, 8'd1, 1'b0, lat, bcnt);
        chk("s128_lat", lat, 10);
        chk("s128_ovf", overflow, 1);
        chk("s128_dz", divzero, 0);
        chk("s128_quot", quot, 8'hFF);
        chk("s128_rem", rem, 8'hFF);
        tick();

        // -128 / 1 signed fits exactly
        run_op(1'b1, 16'hFF80, 8'd1, 1'b0, lat, bcnt);
        chk("sm128_quot", quot, 8'h80);
        chk("sm128_rem", rem, 8'h00);
        chk("sm128_ovf", overflow, 0);
        tick();

        // divide by zero, unsigned
        run_op(1'b0, 16'd1000, 8'd0, 1'b0, lat, bcnt);
        chk("dz_u_lat", lat, 1);
        chk("dz_u_busy_cycles", bcnt, 0);
        chk("dz_u_dz", divzero, 1);
        chk("dz_u_ovf", overflow, 1);
        chk("dz_u_quot", quot, 8'hFF);
        chk("dz_u_rem", rem, 8'hFF);
        tick();
        chk("dz_u_done_one_cycle", done, 0);
        chk("dz_u_busy_after", busy, 0);

        // divide by zero, signed
        run_op(1'b1, 16'hFF9C, 8'd0, 1'b0, lat, bcnt);
        chk("dz_s_lat", lat, 1);
        chk("dz_s_busy_cycles", bcnt, 0);
        chk("dz_s_dz", divzero, 1);
        chk("dz_s_ovf", overflow, 1);
        chk("dz_s_quot", quot, 8'hFF);
        tick();

        // Pre-check overflow: the high byte 7 is >= 7.
        run_op(1'b0, 16'h0700, 8'd7, 1'b0, lat, bcnt);
        chk("pov_lat", lat, 1);
        chk("pov_ovf", overflow, 1);
        chk("pov_dz", divzero, 0);
        chk("pov_quot", quot, 8'hFF);
        chk("pov_rem", rem, 8'hFF);
        tick();

        // go held high: the second operation is accepted in the done cycle
        run_op(1'b0, 16'd1000, 8'd7, 1'b1, lat, bcnt);
        chk("b2b_lat1", lat, 10);
        chk("b2b_quot1", quot, 8'h8E);
        run_op(1'b0, 16'd1000, 8'd7, 1'b1, lat, bcnt);
        go = 1'b0;
        chk("b2b_lat2", lat, 10);
        chk("b2b_busy2", bcnt, 9);
        chk("b2b_quot2", quot, 8'h8E);
        chk("b2b_rem2", rem, 8'h06);
        tick();
        tick();

        // go pulsed mid-iteration with other operands is ignored
        sgn = 1'b0; dividend = 16'd1000; divisor = 8'd7; go = 1'b1;
        tick();
        go = 1'b0;
        n = 1;
        tick(); tick(); n += 2;
        dividend = 16'h0100; divisor = 8'd3; go = 1'b1;
        tick(); n++;
        go = 1'b0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("ign_lat", n, 10);
        chk("ign_quot", quot, 8'h8E);
        chk("ign_rem", rem, 8'h06);
        tick();

        // reset during iteration cycle 4
        sgn = 1'b0; dividend = 16'd1000; divisor = 8'd7; go = 1'b1;
        tick();
        go = 1'b0;
        tick(); tick(); tick(); tick();
        #2;
        arstn = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_quot", quot, 0);
        chk("mrst_rem", rem, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_dz", divzero, 0);
        @(posedge clk);
        #2;
        arstn = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen_done = 1'b1;
        end
        chk("mrst_no_done", seen_done, 0);
        run_op(1'b0, 16'd1000, 8'd7, 1'b0, lat, bcnt);
        chk("mrst_post_lat", lat, 10);
        chk("mrst_post_quot", quot, 8'h8E);
        chk("mrst_post_rem", rem, 8'h06);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
